// File: rtl/alu_pkg.sv
// alu_pkg: shared types for the ALU issue/collect stage.
//   alu_op_e      - 4-bit ALU selector codes (all 16 encodings)
//   alu_cmd_t     - buffered command {a, b, sel}
//   issue_state_e - issue FSM states
//   ALU_DW        - default operand/result width
package alu_pkg;

  localparam int unsigned ALU_DW = 8;

  typedef enum logic [3:0] {
    OP_ADD = 4'b0000,
    OP_SUB = 4'b0001,
    OP_MUL = 4'b0010,
    OP_DIV = 4'b0011,
    OP_MOD = 4'b0100,
    OP_AND = 4'b0101,
    OP_OR  = 4'b0110,
    OP_XOR = 4'b0111,
    OP_NOT = 4'b1000,
    OP_SHL = 4'b1001,
    OP_SHR = 4'b1010,
    OP_ROL = 4'b1011,
    OP_ROR = 4'b1100,
    OP_LT  = 4'b1101,
    OP_GT  = 4'b1110,
    OP_EQ  = 4'b1111
  } alu_op_e;

  typedef struct packed {
    logic [ALU_DW-1:0] a;
    logic [ALU_DW-1:0] b;
    alu_op_e           sel;
  } alu_cmd_t;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } issue_state_e;

  function automatic logic is_div_by_zero(alu_op_e sel, logic [ALU_DW-1:0] b);
    return (sel == OP_DIV) && (b == '0);
  endfunction

endpackage

// File: rtl/alu_op_issue_if.sv
// alu_op_issue_if: bundle of the command stream, ALU operand/result bus and
// result stream around the issue stage.
//   slave  - view of the issue stage (accepts commands, drives the ALU,
//            produces results)
//   master - view of the surroundings (decode side, ALU, result consumer)
interface alu_op_issue_if
  import alu_pkg::*;
#(
  parameter int unsigned DW = ALU_DW
);

  logic          cmd_valid;
  logic          cmd_ready;
  logic [DW-1:0] cmd_a;
  logic [DW-1:0] cmd_b;
  logic [3:0]    cmd_sel;

  logic [DW-1:0] alu_a;
  logic [DW-1:0] alu_b;
  logic [3:0]    alu_sel;
  logic [DW-1:0] alu_out;
  logic          alu_carry;

  logic          res_valid;
  logic          res_ready;
  logic [DW-1:0] res_data;
  logic          res_carry;
  logic          res_zero;
  logic [3:0]    res_sel;
  logic          res_err;

  modport slave (
    input  cmd_valid, cmd_a, cmd_b, cmd_sel,
    output cmd_ready,
    output alu_a, alu_b, alu_sel,
    input  alu_out, alu_carry,
    output res_valid, res_data, res_carry, res_zero, res_sel, res_err,
    input  res_ready
  );

  modport master (
    output cmd_valid, cmd_a, cmd_b, cmd_sel,
    input  cmd_ready,
    input  alu_a, alu_b, alu_sel,
    output alu_out, alu_carry,
    input  res_valid, res_data, res_carry, res_zero, res_sel, res_err,
    output res_ready
  );

endinterface

// File: rtl/alu_op_issue_cmd_fifo.sv
// alu_cmd_fifo: synchronous FIFO of alu_cmd_t, read/write pointers plus an
// occupancy counter. Head entry is visible on rd_data whenever !empty.
//   clk, rst      - clock, synchronous active-high reset (flushes contents)
//   push, wr_data - write at tail (ignored when full)
//   pop           - drop head (ignored when empty)
//   rd_data       - head entry
//   full, empty   - occupancy flags
// DEPTH must be a power of two, at least 2.
module alu_cmd_fifo
  import alu_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     push,
  input  alu_cmd_t wr_data,
  input  logic     pop,
  output alu_cmd_t rd_data,
  output logic     full,
  output logic     empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  alu_cmd_t      mem_q [DEPTH];
  alu_cmd_t      mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push;
  logic          do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_data = mem_q[rd_ptr_q];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = wr_data;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    // Simultaneous push and pop leaves the count unchanged.
    if (do_push && !do_pop) begin
      count_d = count_q + CW'(1);
    end else if (!do_push && do_pop) begin
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/alu_op_issue.sv
// alu_op_issue: issue/collect stage around a purely combinational 8-bit ALU.
// Commands are buffered in alu_cmd_fifo, issued one at a time to registered
// ALU operands, and the ALU result is captured one cycle later and returned
// on a valid/ready result stream with a zero flag and selector echo.
//   clk  - system clock, rising edge
//   rst  - synchronous active-high reset; flushes queue and any result
//   bus  - alu_op_issue_if.slave:
//          cmd_valid/cmd_ready/cmd_a/cmd_b/cmd_sel  command stream
//          alu_a/alu_b/alu_sel -> ALU, alu_out/alu_carry <- ALU
//          res_valid/res_ready/res_data/res_carry/res_zero/res_sel/res_err
// Parameters: DEPTH (FIFO entries, power of two >= 2), DW (must equal ALU_DW).
// Build option ALU_DIVZERO_GUARD_EN: DIV by zero returns 8'hFF with res_err=1;
// without it res_data is always alu_out and res_err is constant 0.
module alu_op_issue
  import alu_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned DW    = ALU_DW
) (
  input logic           clk,
  input logic           rst,
  alu_op_issue_if.slave bus
);

  issue_state_e  state_q, state_d;
  logic [DW-1:0] alu_a_q, alu_a_d;
  logic [DW-1:0] alu_b_q, alu_b_d;
  alu_op_e       alu_sel_q, alu_sel_d;
  logic          res_valid_q, res_valid_d;
  logic [DW-1:0] res_data_q, res_data_d;
  logic          res_carry_q, res_carry_d;
  logic          res_zero_q, res_zero_d;
  alu_op_e       res_sel_q, res_sel_d;
  logic          res_err_q, res_err_d;

  alu_cmd_t      fifo_wr;
  alu_cmd_t      fifo_head;
  logic          fifo_push;
  logic          fifo_pop;
  logic          fifo_full;
  logic          fifo_empty;
  logic          guard_hit;

  assign bus.cmd_ready = !fifo_full && !rst;
  assign fifo_push     = bus.cmd_valid && bus.cmd_ready;

  always_comb begin
    fifo_wr.a   = bus.cmd_a;
    fifo_wr.b   = bus.cmd_b;
    fifo_wr.sel = alu_op_e'(bus.cmd_sel);
  end

  alu_cmd_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (fifo_push),
    .wr_data (fifo_wr),
    .pop     (fifo_pop),
    .rd_data (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

`ifdef ALU_DIVZERO_GUARD_EN
  assign guard_hit = is_div_by_zero(alu_sel_q, alu_b_q);
`else
  assign guard_hit = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_sel_d   = alu_sel_q;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    res_carry_d = res_carry_q;
    res_zero_d  = res_zero_q;
    res_sel_d   = res_sel_q;
    res_err_d   = res_err_q;
    fifo_pop    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop  = 1'b1;
          alu_a_d   = fifo_head.a;
          alu_b_d   = fifo_head.b;
          alu_sel_d = fifo_head.sel;
          state_d   = EXEC;
        end
      end
      EXEC: begin
        res_data_d  = guard_hit ? '1 : bus.alu_out;
        res_zero_d  = !guard_hit && (bus.alu_out == '0);
        res_err_d   = guard_hit;
        res_carry_d = bus.alu_carry;
        res_sel_d   = alu_sel_q;
        res_valid_d = 1'b1;
        state_d     = RESP;
      end
      RESP: begin
        if (bus.res_ready) begin
          res_valid_d = 1'b0;
          // Issue the next command in the same cycle the result leaves,
          // giving one result every two cycles under continuous demand.
          if (!fifo_empty) begin
            fifo_pop  = 1'b1;
            alu_a_d   = fifo_head.a;
            alu_b_d   = fifo_head.b;
            alu_sel_d = fifo_head.sel;
            state_d   = EXEC;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_sel_q   <= OP_ADD;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_carry_q <= 1'b0;
      res_zero_q  <= 1'b0;
      res_sel_q   <= OP_ADD;
      res_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_sel_q   <= alu_sel_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_carry_q <= res_carry_d;
      res_zero_q  <= res_zero_d;
      res_sel_q   <= res_sel_d;
      res_err_q   <= res_err_d;
    end
  end

  assign bus.alu_a     = alu_a_q;
  assign bus.alu_b     = alu_b_q;
  assign bus.alu_sel   = alu_sel_q;
  assign bus.res_valid = res_valid_q;
  assign bus.res_data  = res_data_q;
  assign bus.res_carry = res_carry_q;
  assign bus.res_zero  = res_zero_q;
  assign bus.res_sel   = res_sel_q;
  assign bus.res_err   = res_err_q;

endmodule

// File: tb/tb_alu_op_issue.sv
// Testbench for alu_op_issue: behavioural ALU on the bus, queue-based
// reference of expected results in command order, directed steps followed by
// a randomized run. Honors ALU_DIVZERO_GUARD_EN when defined.
module tb_alu_op_issue;
  import alu_pkg::*;

  typedef struct packed {
    logic [7:0] d;
    logic       c;
    logic       z;
    logic [3:0] s;
    logic       e;
  } res_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alu_op_issue_if #(.DW(8)) bus ();

  alu_op_issue #(
    .DEPTH (4),
    .DW    (8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int   n_tests = 0;
  int   n_fail = 0;
  int   n_acc = 0;
  int   n_results = 0;
  int   cyc = 0;
  int   last_cons_cyc = 0;
  bit   chk_gap = 1'b0;
  bit   have_last = 1'b0;
  bit   last_acc = 1'b0;
  res_t exp_q[$];
  res_t got_q[$];

  // ALU behaviour from the opcode meanings, plain integer arithmetic.
  function automatic logic [8:0] alu_fn(input logic [7:0] a, input logic [7:0] b,
                                        input logic [3:0] sel);
    int   ia;
    int   ib;
    int   r;
    logic c;
    ia = int'(a);
    ib = int'(b);
    r  = 0;
    c  = 1'b0;
    case (sel)
      4'h0: begin r = ia + ib; c = (r > 255); end
      4'h1: begin r = ia - ib; c = (r < 0); end
      4'h2: begin r = ia * ib; c = (r > 255); end
      4'h3: if (ib == 0) begin r = 0; c = 1'b1; end else r = ia / ib;
      4'h4: if (ib == 0) begin r = ia; c = 1'b1; end else r = ia % ib;
      4'h5: r = ia & ib;
      4'h6: r = ia | ib;
      4'h7: r = ia ^ ib;
      4'h8: r = 255 - ia;
      4'h9: begin r = ia * 2; c = (ia >= 128); end
      4'hA: begin r = ia / 2; c = (ia % 2 == 1); end
      4'hB: r = (ia * 2) % 256 + ia / 128;
      4'hC: r = ia / 2 + (ia % 2) * 128;
      4'hD: r = (ia < ib) ? 1 : 0;
      4'hE: r = (ia > ib) ? 1 : 0;
      default: r = (ia == ib) ? 1 : 0;
    endcase
    return {c, r[7:0]};
  endfunction

  always_comb {bus.alu_carry, bus.alu_out} = alu_fn(bus.alu_a, bus.alu_b, bus.alu_sel);

  function automatic res_t model(input logic [7:0] a, input logic [7:0] b, input logic [3:0] sel);
    logic [8:0] r;
    res_t       m;
    r   = alu_fn(a, b, sel);
    m.d = r[7:0];
    m.c = r[8];
    m.z = (r[7:0] == 8'h00);
    m.s = sel;
    m.e = 1'b0;
`ifdef ALU_DIVZERO_GUARD_EN
    if (sel == 4'h3 && b == 8'h00) begin
      m.d = 8'hFF;
      m.z = 1'b0;
      m.e = 1'b1;
    end
`endif
    return m;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock: settle handshakes seen before the edge, advance, check holds.
  task automatic cycle();
    logic r, acc, cons, stall;
    res_t held, e;
    r     = rst;
    acc   = bus.cmd_valid && bus.cmd_ready && !r;
    cons  = bus.res_valid && bus.res_ready && !r;
    stall = bus.res_valid && !bus.res_ready && !r;
    held  = {bus.res_data, bus.res_carry, bus.res_zero, bus.res_sel, bus.res_err};
    if (cons) begin
      check("result_expected", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("sb_data", held.d, e.d);
        check("sb_carry", held.c, e.c);
        check("sb_zero", held.z, e.z);
        check("sb_sel", held.s, e.s);
        check("sb_err", held.e, e.e);
      end
      if (chk_gap && have_last) check("result_gap", cyc - last_cons_cyc, 2);
      last_cons_cyc = cyc;
      have_last     = 1'b1;
      n_results++;
      got_q.push_back(held);
    end
    if (acc) begin
      exp_q.push_back(model(bus.cmd_a, bus.cmd_b, bus.cmd_sel));
      n_acc++;
    end
    last_acc = acc;
    @(posedge clk);
    #1;
    cyc++;
    if (r) exp_q.delete();
    if (stall) begin
      check("hold_valid", bus.res_valid, 1);
      check("hold_data", {bus.res_data, bus.res_carry, bus.res_zero, bus.res_sel, bus.res_err}, held);
    end
  endtask

  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [3:0] s);
    int k;
    k = 0;
    bus.cmd_a     = a;
    bus.cmd_b     = b;
    bus.cmd_sel   = s;
    bus.cmd_valid = 1'b1;
    do begin
      cycle();
      k++;
    end while (!last_acc && k < 100);
    bus.cmd_valid = 1'b0;
    check("send_accepted", last_acc, 1);
  endtask

  task automatic wait_results(input int target, input int budget);
    int k;
    k = 0;
    while (n_results < target && k < budget) begin
      cycle();
      k++;
    end
    check("drain_count", n_results, target);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int base_acc;
    int sent;
    int guard;
    int k;

    rst           = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_a     = '0;
    bus.cmd_b     = '0;
    bus.cmd_sel   = '0;
    bus.res_ready = 1'b0;
    cycle();
    cycle();
    check("rst_cmd_ready_low", bus.cmd_ready, 0);
    rst = 1'b0;
    #1;
    check("rst_cmd_ready", bus.cmd_ready, 1);
    check("rst_res_valid", bus.res_valid, 0);
    check("rst_res_all", {bus.res_data, bus.res_carry, bus.res_zero, bus.res_sel, bus.res_err}, 0);
    check("rst_alu_ops", {bus.alu_a, bus.alu_b, bus.alu_sel}, 0);

    // ADD 200+100: latency and wrap-around carry.
    bus.cmd_a = 8'd200; bus.cmd_b = 8'd100; bus.cmd_sel = 4'h0; bus.cmd_valid = 1'b1;
    cycle();
    check("t1_accept", last_acc, 1);
    bus.cmd_valid = 1'b0;
    check("t1_valid_n", bus.res_valid, 0);
    cycle();
    check("t1_valid_n1", bus.res_valid, 0);
    check("t1_alu_a", bus.alu_a, 200);
    check("t1_alu_b", bus.alu_b, 100);
    cycle();
    check("t1_valid_n2", bus.res_valid, 1);
    check("t1_data", bus.res_data, 44);
    check("t1_carry", bus.res_carry, 1);
    check("t1_zero", bus.res_zero, 0);
    check("t1_sel", bus.res_sel, 0);
    bus.res_ready = 1'b1;
    cycle();
    check("t1_released", bus.res_valid, 0);
    cycle();
    cycle();
    check("t1_ops_hold", {bus.alu_a, bus.alu_b}, {8'd200, 8'd100});

    // XOR to zero, then EQ, in order.
    base = n_results;
    send(8'h5A, 8'h5A, 4'h7);
    send(8'd7, 8'd7, 4'hF);
    wait_results(base + 2, 50);
    check("t2_xor_data", got_q[base].d, 0);
    check("t2_xor_zero", got_q[base].z, 1);
    check("t2_eq_data", got_q[base+1].d, 1);
    check("t2_eq_sel", got_q[base+1].s, 4'hF);

    // Stall: six one-cycle offers, only five fit (one issued + four queued).
    bus.res_ready = 1'b0;
    base     = n_results;
    base_acc = n_acc;
    for (int i = 0; i < 6; i++) begin
      bus.cmd_a     = 8'($urandom);
      bus.cmd_b     = 8'($urandom);
      bus.cmd_sel   = 4'($urandom_range(0, 15));
      bus.cmd_valid = 1'b1;
      if (i == 5) check("t3_full_ready", bus.cmd_ready, 0);
      cycle();
    end
    bus.cmd_valid = 1'b0;
    check("t3_accepted", n_acc - base_acc, 5);
    repeat (4) cycle();
    check("t3_stall_valid", bus.res_valid, 1);
    bus.res_ready = 1'b1;
    chk_gap   = 1'b1;
    have_last = 1'b0;
    wait_results(base + 5, 40);
    chk_gap = 1'b0;

    // Reset while holding a result with three queued: nothing survives.
    bus.res_ready = 1'b0;
    cycle();
    base = n_results;
    for (int i = 0; i < 4; i++) send(8'($urandom), 8'($urandom), 4'($urandom_range(0, 15)));
    k = 0;
    while (!bus.res_valid && k < 20) begin cycle(); k++; end
    check("t4_in_resp", bus.res_valid, 1);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    #1;
    check("t4_res_valid", bus.res_valid, 0);
    check("t4_cmd_ready", bus.cmd_ready, 1);
    check("t4_res_data", bus.res_data, 0);
    check("t4_alu_a", bus.alu_a, 0);
    bus.res_ready = 1'b1;
    repeat (20) cycle();
    check("t4_no_stale", n_results - base, 0);

    // Divide by zero, then a normal divide.
    base = n_results;
    send(8'd9, 8'd0, 4'h3);
    send(8'd9, 8'd3, 4'h3);
    wait_results(base + 2, 30);
`ifdef ALU_DIVZERO_GUARD_EN
    check("t5_dz_data", got_q[base].d, 8'hFF);
    check("t5_dz_err", got_q[base].e, 1);
    check("t5_dz_zero", got_q[base].z, 0);
`else
    check("t5_dz_data", got_q[base].d, 8'h00);
    check("t5_dz_err", got_q[base].e, 0);
    check("t5_dz_zero", got_q[base].z, 1);
`endif
    check("t5_dz_carry", got_q[base].c, 1);
    check("t5_div_data", got_q[base+1].d, 3);
    check("t5_div_err", got_q[base+1].e, 0);

    // Push and pop on the same edge with two queued keeps two queued.
    bus.res_ready = 1'b0;
    base = n_results;
    for (int i = 0; i < 3; i++) send(8'(i + 10), 8'd1, 4'h0);
    bus.cmd_a = 8'd40; bus.cmd_b = 8'd2; bus.cmd_sel = 4'h1; bus.cmd_valid = 1'b1;
    bus.res_ready = 1'b1;
    cycle();
    check("t6_same_edge_push", last_acc, 1);
    bus.res_ready = 1'b0;
    base_acc = n_acc;
    for (int i = 0; i < 3; i++) begin
      bus.cmd_a = 8'(50 + i); bus.cmd_b = 8'd5; bus.cmd_sel = 4'h6; bus.cmd_valid = 1'b1;
      cycle();
    end
    bus.cmd_valid = 1'b0;
    check("t6_room_left", n_acc - base_acc, 2);
    bus.res_ready = 1'b1;
    wait_results(base + 6, 40);

    // Randomized traffic against the reference queue.
    base  = n_results;
    sent  = 0;
    guard = 0;
    while (sent < 1000 && guard < 20000) begin
      bus.cmd_valid = ($urandom_range(0, 3) != 0);
      bus.cmd_a     = 8'($urandom);
      bus.cmd_b     = ($urandom_range(0, 15) == 0) ? 8'h00 : 8'($urandom);
      bus.cmd_sel   = 4'($urandom_range(0, 15));
      bus.res_ready = ($urandom_range(0, 3) != 0);
      cycle();
      if (last_acc) sent++;
      guard++;
    end
    bus.cmd_valid = 1'b0;
    bus.res_ready = 1'b1;
    check("t7_sent", sent, 1000);
    wait_results(base + sent, 200);
    check("t7_sb_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_op_issue.md
Name: alu_op_issue

Overview:
- Issue/collect stage wrapped around the 8-bit combinational ALU.
- Buffers incoming operations from a valid/ready command stream in a small FIFO.
- Presents registered operands and selector to the ALU, captures ALU result and carry one cycle later, and returns them on a valid/ready result stream with a zero flag.
- Sits between the instruction/decode side and the ALU; the ALU itself stays purely combinational.

Parameters:
- DEPTH, 4, command FIFO entries; power of two, at least 2.
- DW, 8, operand/result width; must match the ALU.

Ports:
- clk  in  1  single system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  FIFO can accept; equals !full, forced 0 while rst=1.
- cmd_a  in  DW  operand A.
- cmd_b  in  DW  operand B.
- cmd_sel  in  4  ALU selector code.
- alu_a  out  DW  registered operand A to ALU.
- alu_b  out  DW  registered operand B to ALU.
- alu_sel  out  4  registered selector to ALU.
- alu_out  in  DW  ALU result (combinational from alu_a/alu_b/alu_sel).
- alu_carry  in  1  ALU carry-out.
- res_valid  out  1  result held.
- res_ready  in  1  consumer accepts result.
- res_data  out  DW  captured result.
- res_carry  out  1  captured carry.
- res_zero  out  1  res_data==0.
- res_sel  out  4  selector echo.
- res_err  out  1  error flag; see Optional Feature.

Behaviour:
- Interface: one clock, clk; synchronous active-high reset, rst.
- Reset: every register zero, FIFO empty, state IDLE, res_valid=0, alu_a/alu_b/alu_sel=0, all res_* outputs=0. Reset mid-operation discards FIFO contents and any in-flight or held result; no result is emitted for them.
- Push: cmd_valid && cmd_ready at an edge writes {a,b,sel} at the tail.
- Pop: performed only by the FSM.
- Simultaneous push and pop: allowed when not empty; count is unchanged.
- Full: cmd_ready=0, no push. Commands are never dropped or overwritten.
- FSM states:
  - IDLE: if FIFO not empty, pop head into alu_a/alu_b/alu_sel, go to EXEC.
  - EXEC: capture alu_out, alu_carry, alu_sel and (alu_out==0) into res_*; set res_valid=1; go to RESP.
  - RESP: hold res_* stable while res_valid && !res_ready. On res_ready: if FIFO not empty, pop next into operand registers, clear res_valid, go to EXEC; else clear res_valid, go to IDLE.
- Latency:
  - Command pushed at edge N into an empty FIFO (IDLE) → popped at N+1 → res_valid high after N+2.
  - Back-to-back throughput: one result per 2 cycles while res_ready=1.
- Operand registers hold their last value while in IDLE.
- Ordering: results are emitted strictly in command order.
- Arithmetic: none local except the zero compare; res_carry is whatever the ALU reports, with no reinterpretation by selector.

Optional Feature:
- Macro: ALU_DIVZERO_GUARD_EN.
- Defined: in EXEC, if alu_sel==4'b0011 and alu_b==0, res_data=8'hFF, res_zero=0, res_err=1, res_carry as reported by the ALU. res_err=0 for all other operations.
- Undefined: res_data is taken from alu_out unconditionally; res_err is tied to 0.

Decomposition:
- alu_pkg:
  - op-code enum covering all 16 selector codes (OP_ADD=0000 … OP_EQ=1111).
  - DW default.
  - packed struct alu_cmd_t {a, b, sel}.
  - FSM state enum {IDLE, EXEC, RESP}.
- Sub-module alu_cmd_fifo: synchronous FIFO of alu_cmd_t; pointer-plus-count, full/empty outputs.
- The FSM and result registers stay in alu_op_issue.

Test Plan:
- Reset, then push ADD a=200 b=100 → res_valid after 3 edges, res_data=44, res_carry=1, res_zero=0, res_sel=0000.
- XOR a=0x5A b=0x5A, res_ready=1 → res_data=0x00, res_zero=1; then EQ a=7 b=7 → res_data=1, in order.
- Hold res_ready=0 and present 6 commands (DEPTH=4) → exactly 5 accepted, cmd_ready=0 on the 6th. Release res_ready → 5 results in order, one every 2 cycles, and res_data holds steady while stalled.
- Assert rst for 1 cycle while in RESP with 3 queued → res_valid=0, cmd_ready=1 after reset; no stale results emitted afterwards.
- DIV a=9 b=0 with ALU_DIVZERO_GUARD_EN defined → res_data=0xFF, res_err=1. Without the macro → res_err=0 and res_data equals alu_out.
- Push and pop in the same cycle with 2 entries queued → count stays 2, no entry lost or duplicated, checked by a scoreboard over 1000 random commands.
